// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares one register-file write port between NREQ writeback
// sources using a round-robin arbiter with a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid[NREQ]     requester i has a write pending
//   req_addr/req_data   per-requester destination register / write data (slice i)
//   req_ready[NREQ]     one-hot grant; transfer when valid & ready
//   wb_stall            blocks all grants this cycle
//   rf_we/rf_addr/rf_din registered write strobe, address, data
//   wb_count            committed non-r0 writes (wraps)
//   last_gnt            one-hot of most recent granted requester

// Per-lane eligibility: lane is in the "upper" search window when it is
// valid and sits at or after the rotating priority pointer.
module rf_wb_lane #(
  parameter int IDX   = 0,
  parameter int PTR_W = 1
) (
  input  logic             valid,
  input  logic [PTR_W-1:0] ptr,
  output logic             hi
);
  assign hi = valid && (ptr <= PTR_W'(IDX));
endmodule

module rf_wb_arbiter #(
  parameter int NREQ     = 2,
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 5,
  parameter int CNT_WID  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ-1:0][ADDR_WID-1:0]      req_addr,
  input  logic [NREQ-1:0][DATA_WID-1:0]      req_data,
  output logic [NREQ-1:0]                    req_ready,
  input  logic                               wb_stall,
  output logic                               rf_we,
  output logic [ADDR_WID-1:0]                rf_addr,
  output logic [DATA_WID-1:0]                rf_din,
  output logic [CNT_WID-1:0]                 wb_count,
  output logic [NREQ-1:0]                    last_gnt
);
  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] ptr;
  logic [NREQ-1:0]  hi_vec;
  logic [PTR_W-1:0] hi_idx, lo_idx, sel;
  logic             xfer;
  logic [ADDR_WID-1:0] sel_addr;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    rf_wb_lane #(.IDX(i), .PTR_W(PTR_W)) u_lane (
      .valid (req_valid[i]),
      .ptr   (ptr),
      .hi    (hi_vec[i])
    );
  end

  // Lowest eligible index at/after ptr; fall back to lowest valid overall
  // (the wrapped part of the search). Descending loops leave the lowest hit.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (hi_vec[i])    hi_idx = PTR_W'(i);
      if (req_valid[i]) lo_idx = PTR_W'(i);
    end
    sel = (|hi_vec) ? hi_idx : lo_idx;
  end

  // Grant depends only on valid, stall and ptr -- never on addr/data.
  assign req_ready = (!wb_stall && |req_valid)
                     ? ({{(NREQ-1){1'b0}}, 1'b1} << sel) : '0;
  assign xfer      = |req_ready;
  assign sel_addr  = req_addr[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_din   <= '0;
      wb_count <= '0;
      last_gnt <= '0;
      ptr      <= '0;
    end else if (xfer) begin
      rf_addr  <= sel_addr;
      rf_din   <= req_data[sel];
      // r0 writes are accepted but never strobed or counted
      rf_we    <= |sel_addr;
      if (|sel_addr) wb_count <= wb_count + 1'b1;
      last_gnt <= req_ready;
      ptr      <= (sel == PTR_W'(NREQ-1)) ? '0 : sel + 1'b1;
    end else begin
      rf_we    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int NREQ = 2, DW = 32, AW = 5, CW = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   wb_stall = 1'b0;
  logic                   rf_we;
  logic [AW-1:0]          rf_addr;
  logic [DW-1:0]          rf_din;
  logic [CW-1:0]          wb_count;
  logic [NREQ-1:0]        last_gnt;

  int total = 0, bad = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .DATA_WID(DW), .ADDR_WID(AW), .CNT_WID(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din),
    .wb_count(wb_count), .last_gnt(last_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic        stall;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  ready;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [15:0] cnt;
    logic [1:0]  last;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic s, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid   = v;
    wb_stall    = s;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_data[0] = d0;
    req_data[1] = d1;
  endtask

  initial begin
    //            valid  st  a0 a1 d0            d1             rdy  we addr din           cnt  last
    vecs[0]  = '{2'b01, 0, 3, 0, 32'h1234,      32'h0,         2'b01, 1, 3, 32'h1234,      1, 2'b01};
    vecs[1]  = '{2'b11, 0, 5, 6, 32'h5,         32'h6,         2'b10, 1, 6, 32'h6,         2, 2'b10};
    vecs[2]  = '{2'b11, 0, 5, 6, 32'h5,         32'h6,         2'b01, 1, 5, 32'h5,         3, 2'b01};
    vecs[3]  = '{2'b11, 0, 5, 6, 32'h5,         32'h6,         2'b10, 1, 6, 32'h6,         4, 2'b10};
    vecs[4]  = '{2'b11, 0, 5, 6, 32'h5,         32'h6,         2'b01, 1, 5, 32'h5,         5, 2'b01};
    vecs[5]  = '{2'b10, 0, 5, 0, 32'h5,         32'hFFFF,      2'b10, 0, 0, 32'hFFFF,      5, 2'b10};
    vecs[6]  = '{2'b11, 0, 8, 9, 32'h80,        32'h90,        2'b01, 1, 8, 32'h80,        6, 2'b01};
    vecs[7]  = '{2'b11, 1, 8, 9, 32'h80,        32'h90,        2'b00, 0, 8, 32'h80,        6, 2'b01};
    vecs[8]  = '{2'b11, 1, 8, 9, 32'h80,        32'h90,        2'b00, 0, 8, 32'h80,        6, 2'b01};
    vecs[9]  = '{2'b11, 1, 8, 9, 32'h80,        32'h90,        2'b00, 0, 8, 32'h80,        6, 2'b01};
    vecs[10] = '{2'b11, 0, 8, 9, 32'h80,        32'h90,        2'b10, 1, 9, 32'h90,        7, 2'b10};
    vecs[11] = '{2'b11, 0, 7, 7, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'b01, 1, 7, 32'hAAAA_AAAA, 8, 2'b01};
    vecs[12] = '{2'b10, 0, 7, 7, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'b10, 1, 7, 32'hBBBB_BBBB, 9, 2'b10};
    vecs[13] = '{2'b00, 0, 7, 7, 32'h0,         32'h0,         2'b00, 0, 7, 32'hBBBB_BBBB, 9, 2'b10};

    // reset state
    #2;
    check("rst_we",   0, 64'(rf_we),    64'd0);
    check("rst_addr", 0, 64'(rf_addr),  64'd0);
    check("rst_din",  0, 64'(rf_din),   64'd0);
    check("rst_cnt",  0, 64'(wb_count), 64'd0);
    check("rst_last", 0, 64'(last_gnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].stall, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      check("ready", i, 64'(req_ready), 64'(vecs[i].ready));
      @(posedge clk);
      #1;
      check("we",   i, 64'(rf_we),    64'(vecs[i].we));
      check("addr", i, 64'(rf_addr),  64'(vecs[i].addr));
      check("din",  i, 64'(rf_din),   64'(vecs[i].din));
      check("cnt",  i, 64'(wb_count), 64'(vecs[i].cnt));
      check("last", i, 64'(last_gnt), 64'(vecs[i].last));
    end

    // Stall right after a registered write: the pending strobe still issues.
    @(negedge clk);
    drive(2'b01, 0, 4, 0, 32'h44, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b01, 1, 4, 0, 32'h44, 32'h0);
    #1;
    check("stall_ready", 0, 64'(req_ready), 64'd0);
    check("stall_we_pending", 0, 64'(rf_we), 64'd1);
    @(posedge clk);
    #1;
    check("stall_we_after", 0, 64'(rf_we), 64'd0);
    check("stall_cnt", 0, 64'(wb_count), 64'd10);

    // Async reset mid-stream, between edges, during back-to-back grants.
    @(negedge clk);
    drive(2'b11, 0, 10, 11, 32'h100, 32'h110);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("mid_we_pre", 0, 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_we",   0, 64'(rf_we),    64'd0);
    check("arst_cnt",  0, 64'(wb_count), 64'd0);
    check("arst_last", 0, 64'(last_gnt), 64'd0);
    check("arst_addr", 0, 64'(rf_addr),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // ptr cleared: first grant searches from requester 0
    check("arst_ready", 0, 64'(req_ready), 64'b01);
    @(posedge clk);
    #1;
    check("arst_first_addr", 0, 64'(rf_addr), 64'd10);
    check("arst_first_cnt",  0, 64'(wb_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the single register-file write port between NREQ writeback sources, e.g. the ALU pipe, the load unit and the mul/div unit.
- Arbitration is round-robin with a valid/ready handshake.
- The winner's address and data are registered and presented as a one-cycle write strobe to the register file's write port.
- A stall input freezes arbitration, for example while the register file is being debug-read.

Parameters:
NREQ, 2, number of writeback requesters (2..4)
DATA_WID, 32, write data width
ADDR_WID, 5, register address width
CNT_WID, 16, width of committed-write counter

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  requester i has a write pending
req_addr  in  NREQ*ADDR_WID  destination register of requester i, packed as slice i
req_data  in  NREQ*DATA_WID  write data of requester i, packed as slice i
req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both 1
wb_stall  in  1  1 = accept nothing this cycle
rf_we  out  1  write strobe to register file, registered
rf_addr  out  ADDR_WID  write address, registered
rf_din  out  DATA_WID  write data, registered
wb_count  out  CNT_WID  number of committed non-r0 writes
last_gnt  out  NREQ  one-hot index of the most recent granted requester (0 when none yet)

Behaviour:
Reset values (async, while rst_n=0):
- rf_we=0, rf_addr=0, rf_din=0, wb_count=0, last_gnt=0.
- Internal priority pointer ptr=0.

Arbitration (combinational, same cycle):
- If wb_stall=1 or req_valid=0, then req_ready=0.
- Otherwise grant the first i with req_valid[i]=1, searching i = ptr, ptr+1, ..., wrapping modulo NREQ.
- Exactly one req_ready bit is high, and only toward a valid requester.
- req_ready must not depend on req_addr or req_data.

On a transfer from requester g at posedge:
- rf_addr and rf_din load slice g of req_addr and req_data.
- rf_we=1 if slice g of req_addr != 0, else 0. An r0 write is accepted and dropped.
- ptr becomes (g+1) mod NREQ.
- last_gnt becomes the one-hot of g.
- wb_count increments only when rf_we is set. It wraps to 0 after its maximum value, with no saturation.

No transfer in a cycle (stall or no valid request):
- rf_we=0 the next cycle.
- rf_addr, rf_din, ptr and last_gnt hold.

Latency and throughput:
- A request accepted at edge N appears on rf_we/rf_addr/rf_din during cycle N+1 (one-cycle latency).
- Maximum throughput is one write per cycle.

Simultaneous requests to the same register:
- Served in grant order, one per cycle.
- The later grant's data is the final register content. No merging.

Requester rules:
- A requester must hold req_valid, req_addr and req_data stable until its transfer completes.
- The arbiter does not check this.

wb_stall:
- Asserting wb_stall blocks new grants in the same cycle.
- A write already registered still issues its rf_we pulse.

Reset asserted mid-operation:
- All state clears immediately, and any pending registered write is lost.
- After deassertion, the first grant searches from requester 0.

Test Plan:
- Reset, then a single request: rst_n low then high; req_valid=01, addr0=3, data0=32'h1234 -> req_ready=01 that cycle; next cycle rf_we=1, rf_addr=3, rf_din=32'h1234; wb_count=1.
- Round-robin fairness: both requesters valid continuously with addr0=5, addr1=6 -> grants 01,10,01,10; rf_addr sequence 5,6,5,6, one per cycle; last_gnt alternates.
- r0 drop: req_valid=10, addr1=0, data=32'hFFFF -> req_ready=10; next cycle rf_we=0; wb_count unchanged; ptr advances so that a later double request grants requester 0 first.
- Stall: both valid, wb_stall=1 for 3 cycles -> req_ready=00 and rf_we=0 throughout; after release the grant goes to the requester at ptr.
- Same-address collision: addr0=addr1=7, data0=A, data1=B with ptr=0 -> rf writes A then B in consecutive cycles; wb_count increases by 2.
- Async reset mid-stream: assert rst_n low between clock edges during back-to-back grants -> rf_we, wb_count and last_gnt go to 0 immediately without a clock edge.
